// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR frame sequencer.
package fir_ctrl_pkg;

  localparam int FIR_DW = 32;

  localparam logic [1:0] FIR_OP_NOP  = 2'b00;
  localparam logic [1:0] FIR_OP_LOAD = 2'b01;
  localparam logic [1:0] FIR_OP_RUN  = 2'b10;
  localparam logic [1:0] FIR_OP_READ = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    READ  = 3'd4
  } fir_ctrl_state_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Two-entry output FIFO for FIR results. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; a pop of an
// empty FIFO is ignored. head shows the oldest entry.
module fir_out_fifo
  import fir_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [FIR_DW-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [FIR_DW-1:0] head
);

  logic [FIR_DW-1:0] mem_q [2];
  logic [FIR_DW-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Register FIFO state; reset empties it and zeroes the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for the FIR core: clear, load a frame of samples,
// run until the core reports done (or time out), then read results
// out through a 2-entry FIFO onto the output stream.
//
// Streams: a transfer happens on a rising edge where valid and ready
// are both high; a source holds valid/data until that edge.
module fir_frame_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int SIGNAL_LEN  = 1000,
  parameter int RUN_TIMEOUT = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        error,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        fir_reset,
  output logic [31:0] fir_addr,
  output logic [31:0] fir_x,
  output logic [1:0]  fir_op,
  input  logic [31:0] fir_y,
  input  logic        fir_done,
  output logic [2:0]  state_dbg
);

  localparam logic [31:0] LEN_W        = 32'(SIGNAL_LEN);
  localparam logic [31:0] LAST_IDX     = 32'(SIGNAL_LEN - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(RUN_TIMEOUT - 1);

  fir_ctrl_state_t state_q, state_d;
  logic [31:0]     wr_cnt_q, wr_cnt_d;
  logic [31:0]     rd_cnt_q, rd_cnt_d;
  logic [31:0]     pop_cnt_q, pop_cnt_d;
  logic [31:0]     run_cnt_q, run_cnt_d;
  logic            pending_q, pending_d;
  logic            frame_done_q, frame_done_d;
  logic            error_q, error_d;

  logic [1:0]      fifo_count;
  logic [31:0]     fifo_head;
  logic            in_fire;
  logic            out_pop;
  logic [2:0]      slots_used;
  logic            rd_issue;

  // Handshakes and read-issue gating. A pop in this cycle already
  // counts as a freed slot, which keeps one result per cycle flowing.
  always_comb begin
    in_fire    = in_valid && (state_q == LOAD);
    out_pop    = out_valid && out_ready;
    slots_used = {1'b0, fifo_count} + {2'b0, pending_q} - {2'b0, out_pop};
    rd_issue   = (state_q == READ) && (rd_cnt_q < LEN_W) && (slots_used < 3'd2);
  end

  // FIR core control pins, decoded from the current state.
  always_comb begin
    fir_op   = FIR_OP_NOP;
    fir_addr = '0;
    fir_x    = '0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          fir_op   = FIR_OP_LOAD;
          fir_addr = wr_cnt_q;
          fir_x    = in_data;
        end
      end
      RUN: begin
        fir_op = FIR_OP_RUN;
      end
      READ: begin
        if (rd_issue) begin
          fir_op   = FIR_OP_READ;
          fir_addr = rd_cnt_q;
        end
      end
      default: begin
        fir_op = FIR_OP_NOP;
      end
    endcase
  end

  // Next-state, counters and pulse outputs of the frame FSM.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    pop_cnt_d    = pop_cnt_q;
    run_cnt_d    = run_cnt_q;
    pending_d    = rd_issue;
    frame_done_d = 1'b0;
    error_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CLEAR;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          pop_cnt_d = '0;
          run_cnt_d = '0;
        end
      end
      CLEAR: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (in_fire) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
          if (wr_cnt_q == LAST_IDX) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 32'd1;
        // done wins over a coincident timeout
        if (fir_done) begin
          state_d = READ;
        end else if (run_cnt_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      READ: begin
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (out_pop) begin
          pop_cnt_d = pop_cnt_q + 32'd1;
          if (pop_cnt_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame FSM state, counters and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      pop_cnt_q    <= '0;
      run_cnt_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      run_cnt_q    <= run_cnt_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  // fir_y is valid the cycle after a read issue, which is when pending is set.
  fir_out_fifo u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pending_q),
    .push_data (fir_y),
    .pop       (out_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign busy       = (state_q != IDLE);
  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = fifo_head;
  assign frame_done = frame_done_q;
  assign error      = error_q;
  assign fir_reset  = reset || (state_q == CLEAR);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Bench for fir_frame_ctrl with a behavioural 2-tap {1,1} FIR core.
module tb_fir_frame_ctrl;
  import fir_ctrl_pkg::*;

  localparam int LEN = 4;
  localparam int TMO = 20;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic [31:0] fir_y = '0;
  logic        fir_done;
  logic        busy, frame_done, error, in_ready, out_valid, fir_reset;
  logic [31:0] out_data, fir_addr, fir_x;
  logic [1:0]  fir_op;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fir_frame_ctrl #(.SIGNAL_LEN(LEN), .RUN_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .error(error),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fir_reset(fir_reset), .fir_addr(fir_addr), .fir_x(fir_x),
    .fir_op(fir_op), .fir_y(fir_y), .fir_done(fir_done),
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural FIR core ----------------
  logic [31:0] core_x [LEN];
  int          run_cycles = 0;
  bit          done_enable = 1'b0;
  int          done_delay = 1;

  always @(posedge clk) begin
    if (fir_op == 2'b10) run_cycles <= run_cycles + 1;
    else                 run_cycles <= 0;
    if (fir_reset) begin
      for (int i = 0; i < LEN; i++) core_x[i] <= '0;
    end else if (fir_op == 2'b01 && fir_addr < LEN) begin
      core_x[fir_addr[1:0]] <= fir_x;
    end
    if (fir_op == 2'b11 && fir_addr < LEN)
      fir_y <= core_x[fir_addr[1:0]] +
               ((fir_addr[1:0] == 2'd0) ? 32'd0 : core_x[fir_addr[1:0] - 2'd1]);
  end

  assign fir_done = done_enable && (fir_op == 2'b10) && (run_cycles >= done_delay);

  // ---------------- out_ready driver ----------------
  int       ready_mode = 0;
  int       pat_i = 0;
  bit [7:0] pat = 8'b1011_0100;  // bit i = out_ready in step i: 0,0,1,0,1,1,0,1

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pat_i[2:0]]; pat_i++; end
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] samples [LEN];
  logic [31:0] exp_q [$];
  int  wr_idx = 0, rd_idx = 0, pop_idx = 0;
  int  first_rd_cyc = 0, last_rd_cyc = 0, last_pop_cyc = 0;
  bit  seen_valid = 0, prev_done = 0, prev_stall = 0, last_pop_prev = 0;
  bit  expect_err = 0;
  logic [31:0] prev_data = '0;

  function automatic logic [31:0] ref_y(input int i);
    return samples[i] + ((i > 0) ? samples[i-1] : 32'd0);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_done = 0; prev_stall = 0; last_pop_prev = 0;
    end else begin
      if (fir_op == 2'b01) begin
        check("load_valid", 32'(in_valid), 32'd1);
        if (wr_idx < LEN) begin
          check("load_addr", fir_addr, 32'(wr_idx));
          check("load_x", fir_x, samples[wr_idx]);
        end else begin
          check("load_extra", 32'(wr_idx), 32'(LEN - 1));
        end
        wr_idx++;
      end
      if (fir_op == 2'b11) begin
        check("read_addr", fir_addr, 32'(rd_idx));
        if (rd_idx == 0) first_rd_cyc = cyc;
        else if (ready_mode == 0) check("read_back2back", 32'(cyc - last_rd_cyc), 32'd1);
        last_rd_cyc = cyc;
        rd_idx++;
      end
      if (prev_done) check("done_to_read", 32'(fir_op), 32'd3);
      prev_done = fir_done;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        check("read_latency", 32'(cyc - first_rd_cyc), 32'd2);
      end
      check("frame_done", 32'(frame_done), 32'(last_pop_prev));
      last_pop_prev = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_underflow", 32'(exp_q.size()), 32'd1);
        else check("out_data", out_data, exp_q.pop_front());
        if (ready_mode == 0 && pop_idx > 0) check("out_back2back", 32'(cyc - last_pop_cyc), 32'd1);
        last_pop_cyc = cyc;
        pop_idx++;
        if (pop_idx == LEN) last_pop_prev = 1;
      end
      check("outstanding_le2", 32'((rd_idx - pop_idx) <= 2), 32'd1);
      if (!expect_err) check("no_error", 32'(error), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    @(posedge clk); #1; start = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("clear_fir_reset", 32'(fir_reset), 32'd1);
    check("clear_busy", 32'(busy), 32'd1);
    check("clear_op", 32'(fir_op), 32'd0);
    check("clear_in_ready", 32'(in_ready), 32'd0);
  endtask

  // gap_mode 0: valid on every other cycle; otherwise random 0..2 idle cycles.
  task automatic feed(input int gap_mode);
    for (int i = 0; i < LEN; i++) begin
      int g;
      g = (gap_mode == 0) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 2));
      repeat (g) begin @(posedge clk); #1; in_valid = 1'b0; in_data = $urandom; end
      @(posedge clk); #1; in_valid = 1'b1; in_data = samples[i];
      if (i == 0) begin
        @(negedge clk);
        check("load_in_ready", 32'(in_ready), 32'd1);
        check("load_fir_reset", 32'(fir_reset), 32'd0);
      end
    end
    @(posedge clk); #1; in_valid = 1'b0; in_data = $urandom;
    @(negedge clk);
  endtask

  task automatic wait_frame_done();
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("state_after_frame", 32'(state_dbg), 32'(IDLE));
    check("read_count", 32'(rd_idx), 32'(LEN));
    check("pop_count", 32'(pop_idx), 32'(LEN));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_error(input int t_run);
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (error) seen = 1;
    end
    check("error_seen", 32'(seen), 32'd1);
    check("error_latency", 32'(cyc - t_run), 32'(TMO));
    check("busy_at_error", 32'(busy), 32'd0);
    check("no_read_issued", 32'(rd_idx), 32'd0);
    check("no_output", 32'(pop_idx), 32'd0);
    @(negedge clk);
    check("error_width", 32'(error), 32'd0);
    expect_err = 0;
  endtask

  task automatic run_frame(input int gap_mode, input int rmode, input bit use_done);
    for (int i = 0; i < LEN; i++) samples[i] = $urandom;
    wr_idx = 0; rd_idx = 0; pop_idx = 0; seen_valid = 0;
    ready_mode  = rmode;
    done_enable = use_done;
    done_delay  = $urandom_range(1, 10);
    expect_err  = !use_done;
    start_frame();
    feed(gap_mode);
    check("run_after_load", 32'(fir_op), 32'd2);
    check("load_count", 32'(wr_idx), 32'(LEN));
    if (use_done) begin
      for (int i = 0; i < LEN; i++) exp_q.push_back(ref_y(i));
      wait_frame_done();
    end else begin
      wait_error(cyc);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before t=200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fir_reset", 32'(fir_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_fir_addr", fir_addr, 32'd0);
    check("rst_fir_x", fir_x, 32'd0);
    check("rst_fir_op", 32'(fir_op), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("post_rst_fir_reset", 32'(fir_reset), 32'd0);

    // in_valid while IDLE is ignored
    @(posedge clk); #1; in_valid = 1'b1; in_data = 32'h55;
    repeat (3) begin
      @(negedge clk);
      check("idle_ignore_op", 32'(fir_op), 32'd0);
      check("idle_ignore_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1; in_valid = 1'b0;

    // directed frame 1,2,3,4 -> 1,3,5,7
    wr_idx = 0; rd_idx = 0; pop_idx = 0; seen_valid = 0;
    for (int i = 0; i < LEN; i++) samples[i] = 32'(i + 1);
    ready_mode = 0; done_enable = 1; done_delay = 3;
    start_frame();
    feed(0);
    check("run_after_load", 32'(fir_op), 32'd2);
    exp_q.push_back(32'd1); exp_q.push_back(32'd3);
    exp_q.push_back(32'd5); exp_q.push_back(32'd7);
    wait_frame_done();

    run_frame(1, 1, 1);   // stalled output pattern
    run_frame(1, 0, 0);   // RUN timeout

    // reset after two input handshakes
    for (int i = 0; i < LEN; i++) samples[i] = $urandom;
    wr_idx = 0; ready_mode = 0; done_enable = 1;
    start_frame();
    @(posedge clk); #1; in_valid = 1'b1; in_data = samples[0];
    @(posedge clk); #1; in_data = samples[1];
    @(posedge clk); #1; in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("midrst_fir_reset", 32'(fir_reset), 32'd1);
    check("midrst_loaded", 32'(wr_idx), 32'd2);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    run_frame(0, 0, 1);

    for (int f = 0; f < 6; f++) run_frame(1, 2, 1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_frame_ctrl.md
# fir_frame_ctrl

Frame sequencer for the FIR filter core. It accepts a frame of `SIGNAL_LEN` input samples on a valid/ready stream and clears the filter. It then writes the samples into the filter (op 01), holds compute (op 10) until the filter reports done, and streams the `SIGNAL_LEN` results out on a second valid/ready stream (op 11 reads). It sits between the sample source/sink and the FIR core and owns every FIR control pin.

## Interface
Parameters:
- `SIGNAL_LEN`, 1000: samples per frame; must equal the FIR core `signalLength`.
- `RUN_TIMEOUT`, 500000: maximum cycles allowed in RUN before the frame aborts.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after the last output handshake.
- `error`  out  1  one-cycle pulse on RUN timeout.
- `in_valid`, `in_data[31:0]`  in  input sample stream.
- `in_ready`  out  1  high only in LOAD.
- `out_valid`, `out_data[31:0]`  out  result stream (head of the output FIFO).
- `out_ready`  in  1  sink accepts result.
- `fir_reset`  out  1  drives the FIR core `reset`.
- `fir_addr`  out  32  drives the FIR core `addr`.
- `fir_x`  out  32  drives the FIR core `x`.
- `fir_op`  out  2  drives the FIR core `operation`.
- `fir_y`  in  32  FIR core `y`; valid 1 cycle after an op-11 cycle.
- `fir_done`  in  1  FIR core `done`.

## Operation
- States: IDLE, CLEAR, LOAD, RUN, READ.
- IDLE:
  - `fir_op`=00, `in_ready`=0.
  - `start`=1 → CLEAR.
- CLEAR: one cycle with `fir_reset`=1 and `fir_op`=00 → LOAD.
- LOAD:
  - `in_ready`=1.
  - `fir_op`=01 exactly in cycles where `in_valid`=1, with `fir_addr`=`wr_cnt` and `fir_x`=`in_data` (combinational).
  - `wr_cnt` increments on each handshake. A handshake with `wr_cnt`=`SIGNAL_LEN`-1 → RUN.
- RUN:
  - `fir_op`=10 continuously and `run_cnt` increments each cycle.
  - `fir_done`=1 → READ.
  - If `run_cnt` reaches `RUN_TIMEOUT` first: pulse `error`, then go to IDLE.
- READ:
  - Issue a read by driving `fir_op`=11 and `fir_addr`=`rd_cnt` when `rd_cnt`<`SIGNAL_LEN` and (`fifo_count` + `pending`) < 2, counting a pop in the same cycle as freeing a slot. Otherwise `fir_op`=00.
  - `pending` is set on issue; the next cycle `fir_y` is pushed into a 2-entry output FIFO.
  - Reads are issued in address order 0..`SIGNAL_LEN`-1 and results leave in the same order.
  - The last result popped (`out_valid`&`out_ready` with `pop_cnt`=`SIGNAL_LEN`-1) pulses `frame_done` → IDLE.
- `fir_reset` = `reset` OR (state==CLEAR). Asserting `reset` therefore also clears the FIR core.
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored; no data is consumed.
- Counters are 32-bit unsigned and never wrap within a frame. All counters clear on entry to CLEAR.

## Timing
- Reset values:
  - state=IDLE.
  - `busy`, `frame_done`, `error`, `in_ready`, `out_valid` = 0.
  - `out_data`, `fir_addr`, `fir_x` = 0; `fir_op`=00.
  - `fir_reset`=1 while `reset` is high.
  - FIFO empty, `pending`=0.
- Latencies:
  - `start` to first `in_ready`: 2 cycles (IDLE→CLEAR→LOAD).
  - Last input handshake to `fir_op`=10: next cycle.
  - `fir_done` to first op 11: next cycle.
  - Op-11 issue to `out_valid`: 2 cycles (capture, then FIFO head).
- With `out_ready` held high, READ sustains 1 result per cycle. Total READ length is `SIGNAL_LEN`+2 cycles.
- `out_valid`/`out_data` stay stable while `out_ready`=0. The FIFO never overflows: `fifo_count` + `pending` ≤ 2 at all times.
- `fir_done` asserted in the same cycle as a timeout takes priority: go to READ, no `error`.
- `reset` mid-frame: return to IDLE next cycle. FIFO, `pending` and counters are cleared; partial frames are discarded.
- `frame_done` and `error` are registered pulses; each is high for exactly one cycle.

## Structure
- Shared package `fir_ctrl_pkg`:
  - state enum `fir_ctrl_state_t` (IDLE, CLEAR, LOAD, RUN, READ).
  - op constants `FIR_OP_NOP`=2'b00, `FIR_OP_LOAD`=2'b01, `FIR_OP_RUN`=2'b10, `FIR_OP_READ`=2'b11.
  - data width constant `FIR_DW`=32.
- Sub-module `fir_out_fifo`: 2-entry, 32-bit, synchronous-reset FIFO with push/pop/count/head, used for the output stream.
- The FSM, counters and read-issue logic live in `fir_frame_ctrl`.

## Test plan
The bench uses `SIGNAL_LEN`=4 and a behavioural FIR core with 2 coefficients {1,1}.
- Reset for 3 cycles → all outputs at their reset values, `fir_reset`=1, `busy`=0; `start` pulse → `fir_reset` high 1 cycle, `in_ready`=1 two cycles after `start`.
- Feed 1,2,3,4 with `in_valid` gapped every other cycle → `fir_op`=01 exactly 4 times with (`addr`,`x`) = (0,1),(1,2),(2,3),(3,4); `fir_op`=10 the cycle after the last handshake.
- `fir_done` rises, `out_ready`=1 → op-11 addresses 0,1,2,3 on consecutive cycles. `out_data` = 1,3,5,7 on 4 consecutive `out_valid` cycles, then `frame_done` pulses once and `busy`=0.
- `out_ready` pattern 0,0,1,0,1,1,0,1 → same 1,3,5,7 with no loss or duplication; `out_data` stable while stalled; never more than 2 outstanding reads.
- `fir_done` held at 0 with `RUN_TIMEOUT`=20 → `error` pulses 20 cycles after entering RUN, state IDLE, no op-11 issued.
- `reset` after 2 input handshakes → IDLE next cycle, `fir_reset`=1 during reset; a new `start` loads from addr 0 and completes the frame normally.
